mima_lsu: RTL

Parametrised load/store unit sitting between the execute stage and the data-memory port. Generalises the RV32 load/store funct3 set to an XLEN parameter (RV64 adds LD/LWU/SD), and for each access generates byte strobes, aligned bus addresses and sign/zero-extended load results. Uses one outstanding memory transaction at a time. Operand-side and bus-side handshakes are both valid/ready, driven by a small FSM.

---
 rtl/mima_lsu.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/mima_lsu.sv
// mima_lsu: single-outstanding load/store unit with byte-lane steering and load extension.
// Define MIMA_LSU_MISALIGN_EN to split misaligned accesses instead of raising exc=01.
module mima_lsu #(
    parameter int XLEN = 32
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_req_store,
    input  logic [2:0]        i_req_funct3,
    input  logic [XLEN-1:0]   i_req_addr,
    input  logic [XLEN-1:0]   i_req_wdata,
    input  logic [4:0]        i_req_rd,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [XLEN-1:0]   o_rsp_data,
    output logic [4:0]        o_rsp_rd,
    output logic [1:0]        o_rsp_exc,
    output logic              o_mem_req_valid,
    input  logic              i_mem_req_ready,
    output logic              o_mem_we,
    output logic [XLEN-1:0]   o_mem_addr,
    output logic [XLEN-1:0]   o_mem_wdata,
    output logic [XLEN/8-1:0] o_mem_wstrb,
    input  logic              i_mem_rsp_valid,
    input  logic [XLEN-1:0]   i_mem_rsp_data,
    input  logic              i_mem_rsp_err
);
    localparam int NB   = XLEN / 8;
    localparam int OFFW = $clog2(NB);

`ifdef MIMA_LSU_MISALIGN_EN
    typedef enum logic [2:0] {IDLE, REQ, WAIT, REQ2, WAIT2, RESP} state_t;
`else
    typedef enum logic [2:0] {IDLE, REQ, WAIT, RESP} state_t;
`endif

    state_t          r_state, w_next;
    logic            r_store;
    logic [2:0]      r_funct3;
    logic [XLEN-1:0] r_addr, r_wdata;
    logic [4:0]      r_rd;
    logic            r_rspValid, r_memReqValid, r_memWe;
    logic [XLEN-1:0] r_rspData, r_memAddr, r_memWdata;
    logic [4:0]      r_rspRd;
    logic [1:0]      r_rspExc;
    logic [NB-1:0]   r_memWstrb;

    logic            w_store, w_illegal;
    logic [2:0]      w_funct3;
    logic [XLEN-1:0] w_addr, w_wdata, w_busAddr, w_busWdata, w_loadRaw, w_loadExt;
    logic [OFFW-1:0] w_off;
    logic [7:0]      w_lanes;
    logic [NB-1:0]   w_busStrb;

    // While idle the incoming request drives the decode; afterwards the latched copy does.
    always_comb begin
        w_store  = (r_state == IDLE) ? i_req_store  : r_store;
        w_funct3 = (r_state == IDLE) ? i_req_funct3 : r_funct3;
        w_addr   = (r_state == IDLE) ? i_req_addr   : r_addr;
        w_wdata  = (r_state == IDLE) ? i_req_wdata  : r_wdata;
        case (w_funct3[1:0])
            2'd0:    w_lanes = 8'h01;
            2'd1:    w_lanes = 8'h03;
            2'd2:    w_lanes = 8'h0F;
            default: w_lanes = 8'hFF;
        endcase
    end

    assign w_off      = w_addr[OFFW-1:0];
    assign w_illegal  = (w_store && w_funct3[2])
                     || (!w_store && w_funct3 == 3'b111)
                     || (XLEN == 32 && w_funct3[1:0] == 2'b11)
                     || (XLEN == 32 && !w_store && w_funct3 == 3'b110);
    assign w_busAddr  = {w_addr[XLEN-1:OFFW], {OFFW{1'b0}}};
    assign w_busWdata = w_wdata << {w_off, 3'b000};
    assign w_busStrb  = NB'(w_lanes << w_off);

`ifdef MIMA_LSU_MISALIGN_EN
    logic            w_cross;
    logic [XLEN-1:0] w_beat2Wdata;
    logic [NB-1:0]   w_beat2Strb;
    logic [XLEN-1:0] r_rdata1;

    // The second beat carries whatever lanes spilled past the first bus word.
    assign w_cross      = (int'(w_off) + (1 << int'(w_funct3[1:0]))) > NB;
    assign w_beat2Wdata = w_wdata >> (8 * (NB - int'(w_off)));
    assign w_beat2Strb  = NB'(w_lanes >> (NB - int'(w_off)));
`else
    logic            w_misaligned;
    assign w_misaligned = |(w_addr[2:0] & 3'((4'd1 << w_funct3[1:0]) - 4'd1));
`endif

    always_comb begin
        w_loadRaw = i_mem_rsp_data >> {r_addr[OFFW-1:0], 3'b000};
`ifdef MIMA_LSU_MISALIGN_EN
        if (r_state == WAIT2)
            w_loadRaw = (r_rdata1 >> {r_addr[OFFW-1:0], 3'b000})
                      | (i_mem_rsp_data << (8 * (NB - int'(r_addr[OFFW-1:0]))));
`endif
        case (r_funct3)
            3'b000:  w_loadExt = XLEN'(signed'(w_loadRaw[7:0]));
            3'b001:  w_loadExt = XLEN'(signed'(w_loadRaw[15:0]));
            3'b010:  w_loadExt = XLEN'(signed'(w_loadRaw[31:0]));
            3'b100:  w_loadExt = XLEN'(w_loadRaw[7:0]);
            3'b101:  w_loadExt = XLEN'(w_loadRaw[15:0]);
            3'b110:  w_loadExt = XLEN'(w_loadRaw[31:0]);
            default: w_loadExt = w_loadRaw;
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (i_req_valid) begin
                    if (w_illegal) w_next = RESP;
`ifndef MIMA_LSU_MISALIGN_EN
                    else if (w_misaligned) w_next = RESP;
`endif
                    else w_next = REQ;
                end
            end
            REQ:  if (i_mem_req_ready) w_next = WAIT;
            WAIT: begin
                if (i_mem_rsp_valid) begin
                    w_next = RESP;
`ifdef MIMA_LSU_MISALIGN_EN
                    if (!i_mem_rsp_err && w_cross) w_next = REQ2;
`endif
                end
            end
`ifdef MIMA_LSU_MISALIGN_EN
            REQ2:  if (i_mem_req_ready) w_next = WAIT2;
            WAIT2: if (i_mem_rsp_valid) w_next = RESP;
`endif
            RESP: if (i_rsp_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= IDLE;
            r_store       <= 1'b0;
            r_funct3      <= '0;
            r_addr        <= '0;
            r_wdata       <= '0;
            r_rd          <= '0;
            r_rspValid    <= 1'b0;
            r_rspData     <= '0;
            r_rspRd       <= '0;
            r_rspExc      <= '0;
            r_memReqValid <= 1'b0;
            r_memWe       <= 1'b0;
            r_memAddr     <= '0;
            r_memWdata    <= '0;
            r_memWstrb    <= '0;
`ifdef MIMA_LSU_MISALIGN_EN
            r_rdata1      <= '0;
`endif
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && i_req_valid) begin
                r_store  <= i_req_store;
                r_funct3 <= i_req_funct3;
                r_addr   <= i_req_addr;
                r_wdata  <= i_req_wdata;
                r_rd     <= i_req_rd;
            end
            if (r_memReqValid && i_mem_req_ready)
                r_memReqValid <= 1'b0;
            if (r_state == IDLE && w_next == REQ) begin
                r_memReqValid <= 1'b1;
                r_memWe       <= i_req_store;
                r_memAddr     <= w_busAddr;
                r_memWdata    <= i_req_store ? w_busWdata : '0;
                r_memWstrb    <= i_req_store ? w_busStrb : '0;
            end
`ifdef MIMA_LSU_MISALIGN_EN
            if (w_next == REQ2) begin
                r_rdata1      <= i_mem_rsp_data;
                r_memReqValid <= 1'b1;
                r_memAddr     <= r_memAddr + XLEN'(NB);
                r_memWdata    <= r_store ? w_beat2Wdata : '0;
                r_memWstrb    <= r_store ? w_beat2Strb : '0;
            end
`endif
            // Early exceptions come straight from IDLE; bus completions from a wait state.
            if (w_next == RESP && r_state != RESP) begin
                r_rspValid <= 1'b1;
                if (r_state == IDLE) begin
                    r_rspRd   <= i_req_rd;
                    r_rspExc  <= w_illegal ? 2'b10 : 2'b01;
                    r_rspData <= '0;
                end else begin
                    r_rspRd   <= r_rd;
                    r_rspExc  <= i_mem_rsp_err ? 2'b11 : 2'b00;
                    r_rspData <= (i_mem_rsp_err || r_store) ? '0 : w_loadExt;
                end
            end
            if (r_state == RESP && i_rsp_ready)
                r_rspValid <= 1'b0;
        end
    end

    assign o_req_ready     = (r_state == IDLE);
    assign o_rsp_valid     = r_rspValid;
    assign o_rsp_data      = r_rspData;
    assign o_rsp_rd        = r_rspRd;
    assign o_rsp_exc       = r_rspExc;
    assign o_mem_req_valid = r_memReqValid;
    assign o_mem_we        = r_memWe;
    assign o_mem_addr      = r_memAddr;
    assign o_mem_wdata     = r_memWdata;
    assign o_mem_wstrb     = r_memWstrb;

endmodule
